// File: rtl/audio_mix_pkg.sv
// Shared constants and saturating arithmetic for the two-channel audio mixer.
// Covers the Q2.14 shift, control/status bit positions and the saturating sum.
package audio_mix_pkg;

  localparam int QSHIFT       = 14;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MUTE    = 1;
  localparam int CTRL_CLR     = 2;

  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 16;
  localparam int STAT_BUSY    = 16;

  localparam int SAT_W        = 64;

  typedef struct packed {
    logic                    clip;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  // Operands arrive sign-extended to SAT_W; one guard bit keeps the raw sum exact.
  function automatic sat_t sat_sum(input logic signed [SAT_W-1:0] a,
                                   input logic signed [SAT_W-1:0] b,
                                   input int unsigned             w);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] mx;
    logic signed [SAT_W:0] mn;
    sat_t                  r;
    one    = {{SAT_W{1'b0}}, 1'b1};
    s      = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    mx     = (one <<< (w - 1)) - one;
    mn     = -mx - one;
    r.clip = 1'b0;
    r.val  = s[SAT_W-1:0];
    if (s > mx) begin
      r.clip = 1'b1;
      r.val  = mx[SAT_W-1:0];
    end else if (s < mn) begin
      r.clip = 1'b1;
      r.val  = mn[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_gain_mul.sv
// One channel of the mixer's first stage: signed sample x Q2.14 gain, floor-shifted.
// The product register loads only on an accepted input pair.
module audio_gain_mul
  import audio_mix_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int GAIN_W = 16
) (
  input  logic                                  clk,
  input  logic                                  i_en,
  input  logic signed [DATA_W-1:0]              i_sample,
  input  logic signed [GAIN_W-1:0]              i_gain,
  output logic signed [DATA_W+GAIN_W-QSHIFT-1:0] o_prod
);

  logic signed [DATA_W+GAIN_W-1:0] w_full;
  logic        [QSHIFT-1:0]        w_frac_unused;

  assign w_full        = i_sample * i_gain;
  // Dropping the fraction bits of a two's-complement product is a floor shift.
  assign w_frac_unused = w_full[QSHIFT-1:0];

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_prod <= w_full[DATA_W+GAIN_W-1:QSHIFT];
    end
  end

endmodule

// File: rtl/audio_mix_gain.sv
// Two-stream gain mixer: S1 scales each channel, S2 sums and saturates to DATA_W.
// Define AUDIO_MIX_CLIP_COUNT_EN to build the 16-bit saturating clip counter.
module audio_mix_gain
  import audio_mix_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int GAIN_W = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic signed [GAIN_W-1:0] gain_a,
  input  logic signed [GAIN_W-1:0] gain_b,
  input  logic        [31:0]       ctrl,
  input  logic signed [DATA_W-1:0] in_a_data,
  input  logic signed [DATA_W-1:0] in_b_data,
  input  logic                     in_a_valid,
  input  logic                     in_b_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [31:0]       status
);

  localparam int PROD_W = DATA_W + GAIN_W - QSHIFT;

  logic                          w_stall;
  logic                          w_accept;
  logic                          r_vld_p1;
  logic                          r_mute_p1;
  logic signed [PROD_W-1:0]      w_prod_a_p1;
  logic signed [PROD_W-1:0]      w_prod_b_p1;
  logic signed [SAT_W-1:0]       w_ext_a;
  logic signed [SAT_W-1:0]       w_ext_b;
  sat_t                          w_sat;
  logic signed [DATA_W-1:0]      w_sat_data;
  logic        [SAT_W-DATA_W-1:0] w_sat_hi_unused;
  logic                          r_vld_p2;
  logic signed [DATA_W-1:0]      r_out_p2;
  logic        [STAT_CNT_W-1:0]  w_clip_cnt;

  // A held output freezes the whole pipe, so ready drops with it.
  assign w_stall  = r_vld_p2 & ~out_ready;
  assign in_ready = ARESETN & ctrl[CTRL_EN] & ~w_stall;
  assign w_accept = in_a_valid & in_b_valid & in_ready;

  // ---- S1: per-channel scale, gains and mute captured with the data ----
  audio_gain_mul #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_mul_a (
    .clk      (ACLK),
    .i_en     (w_accept),
    .i_sample (in_a_data),
    .i_gain   (gain_a),
    .o_prod   (w_prod_a_p1)
  );

  audio_gain_mul #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_mul_b (
    .clk      (ACLK),
    .i_en     (w_accept),
    .i_sample (in_b_data),
    .i_gain   (gain_b),
    .o_prod   (w_prod_b_p1)
  );

  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      r_mute_p1 <= ctrl[CTRL_MUTE];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_vld_p1 <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p1 <= w_accept;
    end
  end

  // ---- S2: sum, saturate, mute ----
  assign w_ext_a         = {{(SAT_W-PROD_W){w_prod_a_p1[PROD_W-1]}}, w_prod_a_p1};
  assign w_ext_b         = {{(SAT_W-PROD_W){w_prod_b_p1[PROD_W-1]}}, w_prod_b_p1};
  assign w_sat           = sat_sum(w_ext_a, w_ext_b, DATA_W);
  assign w_sat_data      = w_sat.val[DATA_W-1:0];
  assign w_sat_hi_unused = w_sat.val[SAT_W-1:DATA_W];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_vld_p2 <= 1'b0;
      r_out_p2 <= '0;
    end else if (!w_stall) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_p2 <= r_mute_p1 ? '0 : w_sat_data;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_out_p2;

`ifdef AUDIO_MIX_CLIP_COUNT_EN
  logic                  r_clip_p2;
  logic [31-CTRL_CLR:0]  w_ctrl_unused;

  assign w_ctrl_unused = ctrl[31:CTRL_CLR+1];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_clip_p2 <= 1'b0;
    end else if (!w_stall && r_vld_p1) begin
      r_clip_p2 <= ~r_mute_p1 & w_sat.clip;
    end
  end

  // Counts a clip once, when its sample leaves S2; clear wins over a same-cycle clip.
  logic [STAT_CNT_W-1:0] r_clip_cnt;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_clip_cnt <= '0;
    end else if (ctrl[CTRL_CLR]) begin
      r_clip_cnt <= '0;
    end else if (r_vld_p2 && out_ready && r_clip_p2 && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + 1'b1;
    end
  end

  assign w_clip_cnt = r_clip_cnt;
`else
  logic [32-CTRL_CLR:0] w_ctrl_unused;

  assign w_ctrl_unused = {ctrl[31:CTRL_CLR], w_sat.clip};
  assign w_clip_cnt    = '0;
`endif

  always_comb begin
    status                                 = '0;
    status[STAT_BUSY]                      = r_vld_p1 | r_vld_p2;
    status[STAT_CNT_LSB +: STAT_CNT_W]     = w_clip_cnt;
  end

endmodule

// File: tb/tb_audio_mix_gain.sv
// Scoreboard bench for audio_mix_gain: expected mixes are queued on accept, checked on delivery.
// Clip-count expectations follow whether AUDIO_MIX_CLIP_COUNT_EN is defined for the build.
module tb_audio_mix_gain;

  localparam int DATA_W = 24;
  localparam int GAIN_W = 16;
`ifdef AUDIO_MIX_CLIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [GAIN_W-1:0] gain_a = '0;
  logic [GAIN_W-1:0] gain_b = '0;
  logic [31:0]       ctrl = '0;
  logic [DATA_W-1:0] in_a_data = '0;
  logic [DATA_W-1:0] in_b_data = '0;
  logic              in_a_valid = 1'b0;
  logic              in_b_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       status;

  audio_mix_gain #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .gain_a     (gain_a),
    .gain_b     (gain_b),
    .ctrl       (ctrl),
    .in_a_data  (in_a_data),
    .in_b_data  (in_b_data),
    .in_a_valid (in_a_valid),
    .in_b_valid (in_b_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .status     (status)
  );

  always #5 ACLK = ~ACLK;

  int                errors = 0;
  int                checks = 0;
  int                n_acc = 0;
  int                n_out = 0;
  bit                last_acc = 1'b0;
  logic [DATA_W-1:0] sb_q[$];

  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                              input logic [GAIN_W-1:0] ga, input logic [GAIN_W-1:0] gb,
                                              input logic mute);
    longint pa, pb, s;
    pa = (longint'($signed(a)) * longint'($signed(ga))) >>> 14;
    pb = (longint'($signed(b)) * longint'($signed(gb))) >>> 14;
    s  = pa + pb;
    if (mute) s = 0;
    else if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return 24'(s);
  endfunction

  // One clock: score the handshakes seen just before the edge, then move to 1 ns past it.
  task automatic step();
    logic [DATA_W-1:0] exp_d;
    @(negedge ACLK);
    last_acc = 1'b0;
    if (ARESETN) begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%h expected no output", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            errors++;
            $display("FAIL sb_data got=%h expected=%h", out_data, exp_d);
          end
        end
      end
      if (in_a_valid && in_b_valid && in_ready) begin
        sb_q.push_back(model(in_a_data, in_b_data, gain_a, gain_b, ctrl[1]));
        n_acc++;
        last_acc = 1'b1;
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (sb_q.size() != 0 || status[16]); i++) step();
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; ctrl = 32'h1; out_ready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rst_out_data got=%h expected=000000", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b expected=0", in_ready); end
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL rst_status got=%h expected=00000000", status); end
    ARESETN = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b expected=1", in_ready); end
  endtask

  task automatic test_basic();
    int acc0;
    gain_a = 16'h4000; gain_b = 16'h4000; ctrl = 32'h1; out_ready = 1'b1;
    in_a_data = 24'h000100; in_b_data = 24'h000200; in_a_valid = 1'b1; in_b_valid = 1'b1;
    acc0 = n_acc;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    checks++; if (n_acc - acc0 !== 1) begin errors++; $display("FAIL basic_accept got=%0d expected=1", n_acc - acc0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got=%b expected=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2 got=%b expected=1", out_valid); end
    checks++; if (out_data !== 24'h000300) begin errors++; $display("FAIL basic_data got=%h expected=000300", out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single got=%b expected=0", out_valid); end
    drain();
  endtask

  task automatic test_patterns();
    int out0;
    out0 = n_out; ctrl = 32'h1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a_data = 24'($urandom_range(0, 2097151)) - 24'd1048576;
      in_b_data = 24'($urandom_range(0, 2097151)) - 24'd1048576;
      gain_a    = 16'($urandom_range(0, 32767)) - 16'h4000;
      gain_b    = 16'($urandom_range(0, 32767)) - 16'h4000;
      in_a_valid = 1'b1; in_b_valid = 1'b1;
      step();
    end
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    drain();
    checks++; if (n_out - out0 !== 8) begin errors++; $display("FAIL patterns_count got=%0d expected=8", n_out - out0); end
  endtask

  task automatic test_mute();
    int acc0;
    gain_a = 16'h4000; gain_b = 16'h4000; ctrl = 32'h3; out_ready = 1'b1;
    in_a_data = 24'h123456; in_b_data = 24'h000001; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0; ctrl = 32'h1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 24'h0) begin errors++; $display("FAIL mute_data got=%b/%h expected=1/000000", out_valid, out_data); end
    gain_a = 16'h7FFF; gain_b = 16'h7FFF; ctrl = 32'h3;
    in_a_data = 24'h7FFFFF; in_b_data = 24'h7FFFFF; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0; ctrl = 32'h1;
    step();
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL mute_sat_data got=%h expected=000000", out_data); end
    drain();
    checks++; if (status[15:0] !== 16'h0) begin errors++; $display("FAIL mute_clip_cnt got=%h expected=0000", status[15:0]); end
    acc0 = n_acc;
    in_a_data = 24'h000010; in_a_valid = 1'b1; in_b_valid = 1'b0;
    repeat (4) step();
    checks++; if (n_acc !== acc0) begin errors++; $display("FAIL half_valid_accept got=%0d expected=%0d", n_acc, acc0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL half_valid_out got=%b expected=0", out_valid); end
    in_a_valid = 1'b0;
  endtask

  task automatic test_saturation();
    ctrl = 32'h5; step(); ctrl = 32'h1;
    gain_a = 16'h7FFF; gain_b = 16'h7FFF; out_ready = 1'b1;
    in_a_data = 24'h7FFFFF; in_b_data = 24'h7FFFFF; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    step();
    checks++; if (out_data !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos got=%h expected=7fffff", out_data); end
    step();
    checks++; if (status[15:0] !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL sat_cnt1 got=%0d expected=%0d", status[15:0], CNT_EN ? 1 : 0); end
    in_a_data = 24'h800000; in_b_data = 24'h800000; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    step();
    checks++; if (out_data !== 24'h800000) begin errors++; $display("FAIL sat_neg got=%h expected=800000", out_data); end
    step();
    checks++; if (status[15:0] !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL sat_cnt2 got=%0d expected=%0d", status[15:0], CNT_EN ? 2 : 0); end
    drain();
  endtask

  task automatic test_clr_clip();
    gain_a = 16'h7FFF; gain_b = 16'h7FFF; ctrl = 32'h1; out_ready = 1'b1;
    in_a_data = 24'h7FFFFF; in_b_data = 24'h7FFFFF; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid got=%b expected=1", out_valid); end
    ctrl = 32'h5;
    step();
    ctrl = 32'h1;
    checks++; if (status[15:0] !== 16'h0) begin errors++; $display("FAIL clr_beats_clip got=%0d expected=0", status[15:0]); end
    step();
    checks++; if (status[15:0] !== 16'h0) begin errors++; $display("FAIL clr_hold got=%0d expected=0", status[15:0]); end
    drain();
  endtask

  task automatic test_back_to_back();
    int idx, stall_left, acc0, out0;
    bit stall_done;
    logic [DATA_W-1:0] held;
    idx = 0; stall_left = 0; stall_done = 1'b0; held = '0;
    acc0 = n_acc; out0 = n_out;
    gain_a = 16'h4000; gain_b = 16'h4000; ctrl = 32'h1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && (n_out - out0) < 4; cyc++) begin
      if (stall_left == 0) out_ready = 1'b1;
      if (!stall_done && out_valid) begin
        stall_done = 1'b1; stall_left = 3; held = out_data; out_ready = 1'b0;
      end
      if (idx < 4) begin
        in_a_data = 24'h001000 * 24'(idx + 1); in_b_data = 24'(idx + 1);
        in_a_valid = 1'b1; in_b_valid = 1'b1;
      end else begin
        in_a_valid = 1'b0; in_b_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b expected=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL stall_hold got=%b/%h expected=1/%h", out_valid, out_data, held); end
        stall_left--;
      end
      step();
      if (last_acc) idx++;
    end
    in_a_valid = 1'b0; in_b_valid = 1'b0; out_ready = 1'b1;
    drain();
    checks++; if (stall_done !== 1'b1) begin errors++; $display("FAIL b2b_stall_seen got=%b expected=1", stall_done); end
    checks++; if (n_acc - acc0 !== 4) begin errors++; $display("FAIL b2b_accepts got=%0d expected=4", n_acc - acc0); end
    checks++; if (n_out - out0 !== 4) begin errors++; $display("FAIL b2b_outputs got=%0d expected=4", n_out - out0); end
  endtask

  task automatic test_enable_drop();
    int acc0, out0;
    out0 = n_out;
    gain_a = 16'h4000; gain_b = 16'h4000; ctrl = 32'h1; out_ready = 1'b1;
    in_a_data = 24'h000111; in_b_data = 24'h000222; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_data = 24'hFFFF00; in_b_data = 24'h000050;
    step();
    ctrl = 32'h0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL endrop_ready got=%b expected=0", in_ready); end
    acc0 = n_acc;
    repeat (4) step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    checks++; if (n_acc !== acc0) begin errors++; $display("FAIL endrop_accept got=%0d expected=%0d", n_acc, acc0); end
    checks++; if (n_out - out0 !== 2) begin errors++; $display("FAIL endrop_drain got=%0d expected=2", n_out - out0); end
    checks++; if (status[16] !== 1'b0) begin errors++; $display("FAIL endrop_busy got=%b expected=0", status[16]); end
    ctrl = 32'h1;
  endtask

  task automatic test_reset_midflight();
    int spurious;
    gain_a = 16'h4000; gain_b = 16'h4000; ctrl = 32'h1; out_ready = 1'b1;
    in_a_data = 24'h000A00; in_b_data = 24'h000B00; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_data = 24'h000C00;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    checks++; if (status[16] !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b expected=1", status[16]); end
    ARESETN = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b expected=0", out_valid); end
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL mid_rst_status got=%h expected=00000000", status); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL mid_rst_data got=%h expected=000000", out_data); end
    sb_q.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL mid_stale got=%0d expected=0", spurious); end
    in_a_data = 24'h000010; in_b_data = 24'h000020; in_a_valid = 1'b1; in_b_valid = 1'b1;
    step();
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 24'h000030) begin errors++; $display("FAIL mid_new got=%b/%h expected=1/000030", out_valid, out_data); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_mute();
    test_saturation();
    test_clr_clip();
    test_back_to_back();
    test_enable_drop();
    test_reset_midflight();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got=%0d expected=0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/audio_mix_gain.md
AUDIO_MIX_GAIN -- requirements
Module: audio_mix_gain

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the signed sample width.
REQ-002 SHALL have parameter GAIN_W, default 16, meaning the signed gain width in Q2.14 format.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports gain_a and gain_b, input, GAIN_W bits each: per-channel gains driven from AXI4-Lite slave registers 0 and 1.
REQ-006 SHALL have port ctrl, input, 32 bits, driven from register 2: bit0 enable, bit1 mute, bit2 clr_clip.
REQ-007 SHALL have ports in_a_data and in_b_data, input, DATA_W bits each: the two sample streams.
REQ-008 SHALL have ports in_a_valid and in_b_valid, input, 1 bit each, and port in_ready, output, 1 bit, shared by both streams.
REQ-009 SHALL have ports out_data, output, DATA_W bits; out_valid, output, 1 bit; and out_ready, input, 1 bit: the mixed sample stream.
REQ-010 SHALL have port status, output, 32 bits, read back as register 3: bits[15:0] clip count, bit16 busy.

Function
REQ-011 SHALL accept an input pair only in a cycle where in_a_valid, in_b_valid, in_ready and ctrl.enable are all 1; one valid without the other is held off.
REQ-012 SHALL drive in_ready = ctrl.enable AND NOT stall, where stall = out_valid AND NOT out_ready.
REQ-013 SHALL sample gain_a, gain_b and ctrl.mute together with the accepted data; register changes affect only later accepts.
REQ-014 SHALL form a 2-stage pipeline. S1 computes the signed products (DATA_W+GAIN_W bits), then arithmetic-shifts each right by 14 (floor truncation). S2 computes the signed sum and saturates it to DATA_W.
REQ-015 SHALL present out_valid exactly 2 cycles after an accept when there is no stall, sustaining 1 sample/cycle throughput.
REQ-016 SHALL, on stall, freeze every pipeline stage and hold out_data stable until out_ready is 1.
REQ-017 SHALL saturate to 2^(DATA_W-1)-1 on positive overflow and to -2^(DATA_W-1) on negative overflow; each saturated output counts as one clip.
REQ-018 SHALL, when the sampled mute bit is 1, output 0 for that sample, consume the input normally and not count a clip.
REQ-019 SHALL, when enable falls mid-operation, stop accepting new pairs while in-flight samples drain and are delivered.
REQ-020 SHALL set status.busy = 1 while any pipeline stage holds a valid sample.

Reset
REQ-021 SHALL, while ARESETN = 0, force out_valid = 0, out_data = 0, clear all stage valid bits, clear the clip count and hold in_ready = 0, all asynchronously.
REQ-022 SHALL discard in-flight samples on reset assertion mid-operation; the first output after release comes from a new accept.

Configuration
REQ-023 SHALL provide macro AUDIO_MIX_CLIP_COUNT_EN, which compiles in the clip counter.
REQ-024 SHALL, with the macro defined, use a 16-bit clip counter that holds at 0xFFFF. It increments on clips only when an S2 sample advances (no stall). While ctrl.clr_clip = 1 it clears, and clear beats a simultaneous clip.
REQ-025 SHALL, with the macro undefined, tie status[15:0] to 0, ignore clr_clip and instantiate no counter logic.

Structure
REQ-026 SHALL place the Q-format shift constant (14), the ctrl bit indices, the status field positions and a saturating-sum function in a shared package, audio_mix_pkg.
REQ-027 SHALL implement the per-channel multiply-and-shift as one sub-module, audio_gain_mul, instantiated twice.

Verification
REQ-028 SHALL cover: gains 0x4000/0x4000, A=0x000100, B=0x000200, out_ready=1 -> out_data=0x000300 two cycles after the accept.
REQ-029 SHALL cover: gains 0x7FFF/0x7FFF, A=B=0x7FFFFF -> out_data=0x7FFFFF and clip count 1; the same with A=B=0x800000 -> 0x800000 and clip count 2.
REQ-030 SHALL cover: 4 back-to-back pairs with out_ready low for 3 cycles after the first output -> in_ready=0 during the stall, out_data held, all 4 outputs delivered in order with none lost.
REQ-031 SHALL cover: mute=1, A=0x123456, B=0x000001 -> out_data=0, clip count unchanged; only in_a_valid asserted -> no accept.
REQ-032 SHALL cover: ARESETN pulsed low with 2 samples in flight -> out_valid=0 immediately, status=0, and no stale output after release.
REQ-033 SHALL cover: clr_clip=1 in the same cycle as a clip with AUDIO_MIX_CLIP_COUNT_EN defined -> count=0; with the macro undefined -> status[15:0]=0 throughout.
